// File: rtl/sr_gcd_ext_if.sv
// Extension handshake and shared-ALU override bundle between the schoolRISCV core and sr_gcd_ext.
// The core side is the master: it drives start/operands and returns the shared ALU result.
interface sr_gcd_ext_if;
  logic        start;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [31:0] aluResult;
  logic [2:0]  aluOper;
  logic [31:0] aluSrcA;
  logic [31:0] aluSrcB;
  logic [8:0]  result;
  logic        ready;

  modport master (
    output start, opA, opB, aluResult,
    input  aluOper, aluSrcA, aluSrcB, result, ready
  );

  modport slave (
    input  start, opA, opB, aluResult,
    output aluOper, aluSrcA, aluSrcB, result, ready
  );
endinterface

// File: rtl/sr_gcd_ext.sv
// Multi-cycle GCD extension unit (subtractive Euclid) borrowing the core's sr_alu.
// Define SR_GCD_FAST_EN for the single-state loop with a local comparator (1 cycle per subtraction).
module sr_gcd_ext (
  input  logic         clk,
  input  logic         rst_n,
  sr_gcd_ext_if.slave  ext
);
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

`ifdef SR_GCD_FAST_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, SUB = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  res_q, res_d;
  logic        lt_q, lt_d;

  logic [2:0]  alu_oper;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic        term;

  assign term = (x_q == 8'd0) || (y_q == 8'd0) || (x_q == y_q);

`ifdef SR_GCD_FAST_EN
  logic lt_w;
  assign lt_w = (x_q < y_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      res_q   <= 8'd0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      lt_q    <= lt_d;
    end
  end

  // Abort on a dropped start takes priority over termination so res stays untouched.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    lt_d      = lt_q;
    alu_oper  = ALU_ADD;
    alu_src_a = 32'd0;
    alu_src_b = 32'd0;
    case (state_q)
      IDLE: begin
        if (ext.start) begin
          x_d = ext.opA;
          y_d = ext.opB;
`ifdef SR_GCD_FAST_EN
          state_d = ITER;
`else
          state_d = CMP;
`endif
        end
      end
`ifdef SR_GCD_FAST_EN
      ITER: begin
        if (!term) begin
          alu_oper  = ALU_SUB;
          alu_src_a = {24'd0, lt_w ? y_q : x_q};
          alu_src_b = {24'd0, lt_w ? x_q : y_q};
        end
        if (!ext.start) begin
          state_d = IDLE;
        end else if (term) begin
          res_d   = (x_q == 8'd0) ? y_q : x_q;
          state_d = DONE;
        end else begin
          lt_d = lt_w;
          if (lt_w) y_d = ext.aluResult[7:0];
          else      x_d = ext.aluResult[7:0];
        end
      end
`else
      CMP: begin
        if (!term) begin
          alu_oper  = ALU_SLTU;
          alu_src_a = {24'd0, x_q};
          alu_src_b = {24'd0, y_q};
        end
        if (!ext.start) begin
          state_d = IDLE;
        end else if (term) begin
          res_d   = (x_q == 8'd0) ? y_q : x_q;
          state_d = DONE;
        end else begin
          lt_d    = ext.aluResult[0];
          state_d = SUB;
        end
      end
      SUB: begin
        alu_oper  = ALU_SUB;
        alu_src_a = {24'd0, lt_q ? y_q : x_q};
        alu_src_b = {24'd0, lt_q ? x_q : y_q};
        if (!ext.start) begin
          state_d = IDLE;
        end else begin
          if (lt_q) y_d = ext.aluResult[7:0];
          else      x_d = ext.aluResult[7:0];
          state_d = CMP;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ext.aluOper = alu_oper;
  assign ext.aluSrcA = alu_src_a;
  assign ext.aluSrcB = alu_src_b;
  assign ext.result  = {1'b0, res_q};
  assign ext.ready   = (state_q == DONE);

  // Upper ALU bits are never needed; lt is only observed in the two-state loop.
  logic unused_bits;
  assign unused_bits = ^{ext.aluResult[31:8], ext.aluResult[0], lt_q};
endmodule
